uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver, on the same 16x-oversample clock. Detects each new byte from the receiver's level-held valid strobe and pushes it into a synchronous FIFO. Presents the bytes to the consumer over a valid/ready handshake with first-word fall-through. Reports fill level, sticky overrun, and a saturating count of dropped bytes.

---
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer that sits directly after the UART
// receiver, in the receiver's 16x-oversample clock domain.
//
// A new byte is detected on the rising edge of the receiver's level-held
// rx_valid. Each new byte is written into a synchronous FIFO. The FIFO is
// read with first-word fall-through: the head byte is always on m_data.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   rx_valid, rx_data  receiver byte strobe (level) and data
//   m_data, m_valid,   consumer side, valid/ready handshake
//   m_ready
//   level, full, empty occupancy 0..DEPTH and the flags derived from it
//   overrun, drop_cnt  sticky drop flag and saturating drop counter
//   clr_overrun        single-cycle pulse that clears overrun and drop_cnt
//
// Handshake: a byte is transferred on every rising clk edge where
// m_valid && m_ready. m_valid depends only on FIFO state and never on
// m_ready. m_data holds steady while m_valid is high and no transfer occurs.
// m_ready sampled while m_valid is low has no effect.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  output logic [7:0]        drop_cnt,
  input  logic              clr_overrun
);

  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              rx_valid_d;
  logic              overrun_q;
  logic [7:0]        drop_q;

  logic push_req;
  logic pop;
  logic do_push;
  logic drop;

  assign full    = (level_q == LEVEL_MAX);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign m_valid = ~empty;
  assign m_data  = mem[rd_ptr];
  assign overrun = overrun_q;
  assign drop_cnt = drop_q;

  // One push per rx_valid high period, however long it lasts.
  assign push_req = rx_valid & ~rx_valid_d;
  assign pop      = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Memory has no reset. Contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      // Reset high: a byte still held on rx_valid across reset release
      // must not look like a fresh rising edge.
      rx_valid_d <= 1'b1;
    end else begin
      rx_valid_d <= rx_valid;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop in the same cycle as clr_overrun wins: the drop is counted as
  // the first drop after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (clr_overrun)        drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (DEPTH=16, DATA_W=8).
// Inputs are driven and outputs sampled 1ns after each rising clk edge.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              overrun;
  logic [7:0]        drop_cnt;
  logic              clr_overrun;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt),
    .clr_overrun (clr_overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int unsigned exp_drop;
  logic        exp_ovr;
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the observable FIFO state against the model.
  task automatic check_state(input string tag);
    check({tag, " level"}, 32'(level), 32'(exp_q.size()));
    check({tag, " empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, " full"},  32'(full),  32'(exp_q.size() == DEPTH));
    if (exp_q.size() != 0) check({tag, " head"}, 32'(m_data), 32'(exp_q[0]));
  endtask

  // Drivers
  // One receiver byte: rx_valid high for hold cycles, then low one cycle.
  task automatic send_byte(input logic [DATA_W-1:0] b, input int hold);
    rx_data  = b;
    rx_valid = 1'b1;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
    end else begin
      exp_ovr = 1'b1;
      if (exp_drop < 255) exp_drop++;
    end
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pop_one(input string tag);
    logic [DATA_W-1:0] e;
    check({tag, " m_valid"}, 32'(m_valid), 32'd1);
    e = exp_q.pop_front();
    check({tag, " data"}, 32'(m_data), 32'(e));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) pop_one(tag);
    check({tag, " empty"}, 32'(empty), 32'd1);
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    exp_ovr  = 1'b0;
    exp_drop = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_drop = 0;
    exp_ovr  = 1'b0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    m_ready  = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) tick();

    check("rst level",   32'(level),    32'd0);
    check("rst empty",   32'(empty),    32'd1);
    check("rst full",    32'(full),     32'd0);
    check("rst m_valid", 32'(m_valid),  32'd0);
    check("rst overrun", 32'(overrun),  32'd0);
    check("rst drop",    32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte held for 16 cycles: exactly one entry, visible after edge.
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    check("single pre m_valid", 32'(m_valid), 32'd0);
    tick();
    check("single m_valid", 32'(m_valid), 32'd1);
    check("single m_data",  32'(m_data),  32'hA5);
    repeat (15) tick();
    rx_valid = 1'b0;
    tick();
    check("single level", 32'(level), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single pop empty", 32'(empty), 32'd1);
    check("single pop level", 32'(level), 32'd0);
    // m_ready while empty is ignored.
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("empty pop level", 32'(level), 32'd0);

    // Burst order: 0x01..0x10 fills the FIFO, then drains in order.
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1);
    check("burst full",  32'(full),  32'd1);
    check("burst level", 32'(level), 32'd16);
    drain("burst");
    // Pointers wrapped: a fresh byte comes out correctly.
    send_byte(8'h5A, 2);
    check_state("wrap");
    drain("wrap");

    // Overrun: two drops while full; head untouched.
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    check("ovr overrun", 32'(overrun),  32'd1);
    check("ovr drop",    32'(drop_cnt), 32'd2);
    check("ovr head",    32'(m_data),   32'h01);
    check("ovr level",   32'(level),    32'd16);
    pulse_clr();
    check("clr overrun", 32'(overrun),  32'd0);
    check("clr drop",    32'(drop_cnt), 32'd0);
    check_state("clr");

    // Push and pop in the same cycle at full: no drop, level stays 16.
    check("simul head", 32'(m_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    m_ready  = 1'b1;
    tick();
    m_ready  = 1'b0;
    rx_valid = 1'b0;
    tick();
    check("simul level",   32'(level),   32'd16);
    check("simul overrun", 32'(overrun), 32'd0);
    drain("simul");

    // Asynchronous reset mid-operation, rx_valid held across release.
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1);
    check("pre-rst level", 32'(level), 32'd5);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async rst level",   32'(level),   32'd0);
    check("async rst m_valid", 32'(m_valid), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("held rx level", 32'(level), 32'd0);
    rx_valid = 1'b0;
    tick();
    send_byte(8'h3C, 2);
    check_state("post-rst");
    drain("post-rst");

    // Saturation: 300 drops while full.
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1);
    for (int i = 0; i < 300; i++) send_byte(8'hEE, 1);
    check("sat drop",    32'(drop_cnt), 32'd255);
    check("sat overrun", 32'(overrun),  32'd1);
    check_state("sat");
    // clr coincident with a drop: the drop wins.
    rx_data     = 8'hEF;
    rx_valid    = 1'b1;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    rx_valid    = 1'b0;
    tick();
    check("clr+drop drop",    32'(drop_cnt), 32'd1);
    check("clr+drop overrun", 32'(overrun),  32'd1);
    drain("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
